// File: rtl/frame_uart_bridge.sv
// rtl/frame_uart_bridge.sv - captures SOF..EOF frames into a FIFO and replays them byte-serially on a UART line
// Optional even-parity bit per byte when UART_PARITY_EN is defined.
module frame_uart_bridge #(
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 1024,
    parameter int          BAUD_DIV   = 1040,
    parameter int          STOP_BITS  = 1,
    parameter logic [7:0]  SOF_CHAR   = 8'h3C,
    parameter logic [7:0]  EOF_CHAR   = 8'hDC
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          rx_init_done,
    input  logic                          pll_lock,
    input  logic [DATA_W-1:0]             data_in,
    input  logic [DATA_W/8-1:0]           k_in,
    input  logic                          trans_en,
    output logic                          tx_serial,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          busy
);
    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(NB);
    localparam logic [NB-1:0] K_LANE0 = NB'(1);

    localparam logic [1:0] CAP_IDLE     = 2'd0;
    localparam logic [1:0] CAP_ARMED    = 2'd1;
    localparam logic [1:0] CAP_IN_FRAME = 2'd2;

    localparam logic [2:0] SER_IDLE   = 3'd0;
    localparam logic [2:0] SER_START  = 3'd1;
    localparam logic [2:0] SER_DATA   = 3'd2;
    localparam logic [2:0] SER_STOP   = 3'd3;
`ifdef UART_PARITY_EN
    localparam logic [2:0] SER_PARITY = 3'd4;
`endif

    logic [1:0]        r_cap_state;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_overflow;

    logic [2:0]        r_ser_state;
    logic [DATA_W-1:0] r_word;
    logic [CW-1:0]     r_baud_cnt;
    logic [2:0]        r_bit_idx;
    logic [BW-1:0]     r_byte_idx;
    logic              r_stop_cnt;
    logic              r_par;
    logic              r_tx;
    logic              r_busy;

    logic w_link_ok, w_sof, w_eof, w_wr_req, w_full, w_empty, w_pop, w_push;

    // A delimiter needs the K flag on lane 0 and on no other lane.
    assign w_link_ok = rx_init_done & pll_lock;
    assign w_sof     = (k_in == K_LANE0) && (data_in[7:0] == SOF_CHAR);
    assign w_eof     = (k_in == K_LANE0) && (data_in[7:0] == EOF_CHAR);

    always_comb begin
        w_wr_req = 1'b0;
        case (r_cap_state)
            CAP_ARMED:    w_wr_req = w_link_ok & w_sof;
            CAP_IN_FRAME: w_wr_req = w_link_ok;
            default:      w_wr_req = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cap_state <= CAP_IDLE;
        end else begin
            case (r_cap_state)
                CAP_IDLE:     if (w_link_ok) r_cap_state <= CAP_ARMED;
                CAP_ARMED:    if (!w_link_ok) r_cap_state <= CAP_IDLE;
                              else if (w_sof) r_cap_state <= CAP_IN_FRAME;
                CAP_IN_FRAME: if (!w_link_ok) r_cap_state <= CAP_IDLE;
                              else if (w_eof) r_cap_state <= CAP_ARMED;
                default:      r_cap_state <= CAP_IDLE;
            endcase
        end
    end

    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = (r_ser_state == SER_IDLE) & trans_en & !w_empty;
    assign w_push  = w_wr_req & (!w_full | w_pop);

    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_wr_req & w_full & !w_pop) r_overflow <= 1'b1;
        end
    end

    // Serialiser: r_word shifts right one bit per data bit, so lane 0 goes first and the next byte lands in [7:0].
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ser_state <= SER_IDLE;
            r_word      <= '0;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_stop_cnt  <= 1'b0;
            r_par       <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else if (r_ser_state == SER_IDLE) begin
            if (w_pop) begin
                r_word      <= r_mem[r_rd_ptr];
                r_ser_state <= SER_START;
                r_baud_cnt  <= '0;
                r_byte_idx  <= '0;
                r_tx        <= 1'b0;
                r_busy      <= 1'b1;
            end
        end else if (r_baud_cnt != CW'(BAUD_DIV - 1)) begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
        end else begin
            r_baud_cnt <= '0;
            case (r_ser_state)
                SER_START: begin
                    r_tx        <= r_word[0];
                    r_par       <= r_word[0];
                    r_word      <= r_word >> 1;
                    r_bit_idx   <= '0;
                    r_ser_state <= SER_DATA;
                end
                SER_DATA: begin
                    if (r_bit_idx != 3'd7) begin
                        r_tx      <= r_word[0];
                        r_par     <= r_par ^ r_word[0];
                        r_word    <= r_word >> 1;
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
`ifdef UART_PARITY_EN
                        r_tx        <= r_par;
                        r_ser_state <= SER_PARITY;
`else
                        r_tx        <= 1'b1;
                        r_stop_cnt  <= 1'b0;
                        r_ser_state <= SER_STOP;
`endif
                    end
                end
`ifdef UART_PARITY_EN
                SER_PARITY: begin
                    r_tx        <= 1'b1;
                    r_stop_cnt  <= 1'b0;
                    r_ser_state <= SER_STOP;
                end
`endif
                SER_STOP: begin
                    if (r_stop_cnt != 1'(STOP_BITS - 1)) begin
                        r_stop_cnt <= 1'b1;
                    end else if (r_byte_idx == BW'(NB - 1)) begin
                        r_ser_state <= SER_IDLE;
                        r_busy      <= 1'b0;
                    end else begin
                        r_byte_idx  <= r_byte_idx + BW'(1);
                        r_tx        <= 1'b0;
                        r_ser_state <= SER_START;
                    end
                end
                default: begin
                    r_ser_state <= SER_IDLE;
                    r_tx        <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign tx_serial  = r_tx;
    assign busy       = r_busy;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
endmodule
